// File: rtl/int_mult_pkg.sv
// rtl/int_mult_pkg.sv - shared types, limits and extended-operand product helper for the integer multiplier
package int_mult_pkg;

  typedef enum logic {MULT_UNSIGNED = 1'b0, MULT_SIGNED = 1'b1} mult_mode_e;

  localparam int INT_MULT_MIN_DM = 2;
  localparam int INT_MULT_MAX_W  = 64;

  // Operands arrive right-aligned; the low wa+wb bits of the result hold the exact product.
  function automatic logic [2*INT_MULT_MAX_W-1:0] int_mult_ext_product(
    input logic [INT_MULT_MAX_W-1:0] a,
    input logic [INT_MULT_MAX_W-1:0] b,
    input int                        wa,
    input int                        wb,
    input mult_mode_e                mode
  );
    logic [2*INT_MULT_MAX_W-1:0] ax;
    logic [2*INT_MULT_MAX_W-1:0] bx;
    logic [2*INT_MULT_MAX_W-1:0] amask;
    logic [2*INT_MULT_MAX_W-1:0] bmask;
    logic                        asign;
    logic                        bsign;
    amask = {(2*INT_MULT_MAX_W){1'b1}} << wa;
    bmask = {(2*INT_MULT_MAX_W){1'b1}} << wb;
    ax    = {{INT_MULT_MAX_W{1'b0}}, a} & ~amask;
    bx    = {{INT_MULT_MAX_W{1'b0}}, b} & ~bmask;
    // ~mask & (mask >> 1) isolates the operand's top bit
    asign = (mode == MULT_SIGNED) && (|(ax & ~amask & (amask >> 1)));
    bsign = (mode == MULT_SIGNED) && (|(bx & ~bmask & (bmask >> 1)));
    if (asign) ax = ax | amask;
    if (bsign) bx = bx | bmask;
    return ax * bx;
  endfunction

endpackage

// File: rtl/int_mult_stage.sv
// rtl/int_mult_stage.sv - one pipeline register slot: valid bit plus payload, load-enabled, cleared by flush/reset
module int_mult_stage
  import int_mult_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         load,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic         valid_q;
  logic         valid_d;
  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = in_valid;
      data_d  = in_data;
    end
    if (flush) valid_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/int_mult_pipe.sv
// rtl/int_mult_pipe.sv - pipelined signed/unsigned integer multiplier with tag sideband, backpressure and flush
// Optional per-stage bubble collapse: INT_MULT_PIPE_BUBBLE_COLLAPSE_EN
module int_mult_pipe
  import int_mult_pkg::*;
#(
  parameter int WIDTHA = 17,
  parameter int WIDTHB = 17,
  parameter int DM     = 4,
  parameter int TAGW   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_signed,
  input  logic [WIDTHA-1:0]        A,
  input  logic [WIDTHB-1:0]        B,
  input  logic [TAGW-1:0]          in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTHA+WIDTHB-1:0] RES,
  output logic [TAGW-1:0]          out_tag,
  output logic                     busy
);

  localparam int PW  = WIDTHA + WIDTHB;
  localparam int S0W = 1 + TAGW + PW;
  localparam int SW  = TAGW + PW;

  if (DM < INT_MULT_MIN_DM) begin : g_bad_dm
    $error("int_mult_pipe: DM must be at least %0d", INT_MULT_MIN_DM);
  end
  if (WIDTHA < 2 || WIDTHB < 2 || WIDTHA > INT_MULT_MAX_W || WIDTHB > INT_MULT_MAX_W) begin : g_bad_w
    $error("int_mult_pipe: operand widths must lie in 2..%0d", INT_MULT_MAX_W);
  end
  if (TAGW < 1) begin : g_bad_tag
    $error("int_mult_pipe: TAGW must be at least 1");
  end

  logic [DM-1:0]     v;
  logic [DM-1:0]     adv;
  logic [S0W-1:0]    s0_data;
  logic [SW-1:0]     sd [1:DM-1];
  logic [SW-1:0]     s1_in;
  mult_mode_e        s0_mode;
  logic [TAGW-1:0]   s0_tag;
  logic [WIDTHA-1:0] s0_a;
  logic [WIDTHB-1:0] s0_b;

  always_comb begin
    adv = '0;
`ifdef INT_MULT_PIPE_BUBBLE_COLLAPSE_EN
    // A stage may move if it is empty or the stage after it moves.
    adv[DM-1] = !v[DM-1] || out_ready;
    for (int k = DM - 2; k >= 0; k--) begin
      adv[k] = !v[k] || adv[k+1];
    end
`else
    adv = {DM{!v[DM-1] || out_ready}};
`endif
  end

  assign in_ready = adv[0] && !flush;

  int_mult_stage #(.W(S0W)) u_s0 (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .load     (adv[0]),
    .in_valid (in_valid && in_ready),
    .in_data  ({in_signed, in_tag, A, B}),
    .out_valid(v[0]),
    .out_data (s0_data)
  );

  assign s0_mode = mult_mode_e'(s0_data[S0W-1]);
  assign s0_tag  = s0_data[PW +: TAGW];
  assign s0_a    = s0_data[WIDTHB +: WIDTHA];
  assign s0_b    = s0_data[WIDTHB-1:0];
  assign s1_in   = {s0_tag, PW'(int_mult_ext_product(INT_MULT_MAX_W'(s0_a), INT_MULT_MAX_W'(s0_b),
                                                     WIDTHA, WIDTHB, s0_mode))};

  for (genvar k = 1; k < DM; k++) begin : g_stage
    logic [SW-1:0] stage_in;
    if (k == 1) begin : g_product
      assign stage_in = s1_in;
    end else begin : g_delay
      assign stage_in = sd[k-1];
    end
    int_mult_stage #(.W(SW)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .load     (adv[k]),
      .in_valid (v[k-1]),
      .in_data  (stage_in),
      .out_valid(v[k]),
      .out_data (sd[k])
    );
  end

  assign out_valid = v[DM-1];
  assign RES       = sd[DM-1][PW-1:0];
  assign out_tag   = sd[DM-1][PW +: TAGW];
  assign busy      = |v;

endmodule

// File: tb/tb_int_mult_pipe.sv
// tb/tb_int_mult_pipe.sv - randomized self-checking bench for int_mult_pipe against an arithmetic scoreboard
module tb_int_mult_pipe;

  localparam int WA = 17;
  localparam int WB = 17;
  localparam int DM = 4;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_signed = 1'b0;
  logic [WA-1:0] A = '0;
  logic [WB-1:0] B = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [WA+WB-1:0] RES;
  logic [TW-1:0] out_tag;
  logic          busy;

  int checks = 0;
  int failures = 0;
  int ocount = 0;

  typedef struct {
    logic [33:0] res;
    logic [3:0]  tag;
  } exp_t;
  exp_t q[$];
  exp_t e;

  logic        stalled_prev = 1'b0;
  logic [33:0] held_res;
  logic [3:0]  held_tag;

  int_mult_pipe #(.WIDTHA(WA), .WIDTHB(WB), .DM(DM), .TAGW(TW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
    .A(A), .B(B), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .RES(RES), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [33:0] model(input logic [16:0] a, input logic [16:0] b, input logic s);
    longint x;
    longint y;
    longint p;
    x = longint'(a);
    y = longint'(b);
    if (s && a[16]) x -= 131072;
    if (s && b[16]) y -= 131072;
    p = x * y;
    return p[33:0];
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      stalled_prev = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        check("sb_nonempty", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("sb_res", RES, e.res);
          check("sb_tag", out_tag, e.tag);
        end
        ocount++;
      end
      if (stalled_prev) begin
        check("hold_valid", out_valid, 1);
        check("hold_res", RES, held_res);
        check("hold_tag", out_tag, held_tag);
      end
      stalled_prev = out_valid && !out_ready && !flush;
      held_res = RES;
      held_tag = out_tag;
      if (flush) begin
        check("flush_in_ready", in_ready, 0);
        q.delete();
      end else if (in_valid && in_ready) begin
        q.push_back('{model(A, B, in_signed), in_tag});
      end
    end
  end

  task automatic send(input logic [16:0] a, input logic [16:0] b, input logic s, input logic [3:0] t);
    int  n;
    logic acc;
    n = 0;
    acc = 1'b0;
    A = a; B = b; in_signed = s; in_tag = t; in_valid = 1'b1;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end
    check("send_accept", acc, 1);
  endtask

  task automatic send_rand();
    send(17'($urandom), 17'($urandom), 1'($urandom), 4'($urandom));
  endtask

  task automatic wait_out(output int n);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
      @(negedge clk);
    end
    check("wait_out", out_valid, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
      @(negedge clk);
    end
    check("drain_busy", busy, 0);
    check("drain_sb_empty", q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    int first;
    int last;
    int cnt;
    int oc0;
    int acc;
    logic [33:0] r0;
    logic [3:0]  t0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_res", RES, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: unsigned max * max, latency
    send(17'h1FFFF, 17'h1FFFF, 1'b0, 4'h3);
    in_valid = 1'b0;
    wait_out(n);
    check("t1_latency_edges", n, DM - 1);
    check("t1_res", RES, 34'h3FFFC0001);
    check("t1_tag", out_tag, 4'h3);
    @(posedge clk); #1;
    drain();

    // 2: signed
    send(17'h1FFFF, 17'h00002, 1'b1, 4'h5);
    in_valid = 1'b0;
    wait_out(n);
    check("t2_neg1x2", RES, 34'h3FFFFFFFE);
    @(posedge clk); #1;
    send(17'h10000, 17'h10000, 1'b1, 4'h6);
    in_valid = 1'b0;
    wait_out(n);
    check("t2_minxmin", RES, 34'h100000000);
    @(posedge clk); #1;
    drain();

    // 3: back-to-back
    first = -1; last = -1; cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (c < 8) begin
        in_valid = 1'b1; A = 17'(c); B = 17'(c + 1); in_signed = 1'b0; in_tag = 4'(c);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (c < 8) check("b2b_in_ready", in_ready, 1);
      if (out_valid) begin
        if (first < 0) first = c;
        last = c;
        check("b2b_res", RES, 64'(cnt * (cnt + 1)));
        check("b2b_tag", out_tag, 64'(cnt));
        cnt++;
      end
      @(posedge clk); #1;
    end
    check("b2b_count", cnt, 8);
    check("b2b_contiguous", last - first + 1, 8);
    drain();

    // 4: output stall
    out_ready = 1'b0;
    repeat (4) send_rand();
    A = 17'($urandom); B = 17'($urandom);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) begin
        r0 = RES;
        t0 = out_tag;
      end
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
      check("stall_res", RES, r0);
      check("stall_tag", out_tag, t0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    oc0 = ocount;
    drain();
    check("stall_release_count", ocount - oc0, 4);

    // 5a: flush with a coincident input
    out_ready = 1'b1;
    repeat (3) send_rand();
    A = 17'h1234; flush = 1'b1;
    @(negedge clk);
    check("flush_not_accepted", in_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_busy", busy, 0);
    check("flush_out_valid", out_valid, 0);
    @(posedge clk); #1;
    drain();

    // 5b: flush coinciding with an output handshake
    repeat (4) send_rand();
    in_valid = 1'b0;
    flush = 1'b1;
    oc0 = ocount;
    @(negedge clk);
    check("flushhs_out_valid_pre", out_valid, 1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flushhs_out_valid_post", out_valid, 0);
    check("flushhs_busy", busy, 0);
    check("flushhs_consumed_once", ocount - oc0, 1);
    @(posedge clk); #1;
    drain();

    // 5c: asynchronous reset mid-cycle
    send(17'h1FFFF, 17'h1FFFF, 1'b0, 4'hA);
    repeat (3) send_rand();
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("arst_res", RES, 0);
    check("arst_out_tag", out_tag, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // 6: fill behind a stalled output
    out_ready = 1'b0;
    send_rand();
    in_valid = 1'b0;
    wait_out(n);
    @(posedge clk); #1;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1; A = 17'($urandom); B = 17'($urandom);
      in_signed = 1'($urandom); in_tag = 4'($urandom);
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk); #1;
    end
`ifdef INT_MULT_PIPE_BUBBLE_COLLAPSE_EN
    check("bubble_accepts", acc, DM - 1);
`else
    check("bubble_accepts", acc, 0);
`endif
    drain();

    // random traffic with corner operands, stalls and occasional flush
    for (int c = 0; c < 600; c++) begin
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      flush     = $urandom_range(0, 40) == 0;
      in_signed = 1'($urandom);
      in_tag    = 4'($urandom);
      case ($urandom_range(0, 4))
        0: A = 17'h1FFFF;
        1: A = 17'h10000;
        2: A = 17'h00000;
        default: A = 17'($urandom);
      endcase
      case ($urandom_range(0, 4))
        0: B = 17'h1FFFF;
        1: B = 17'h10000;
        2: B = 17'h0FFFF;
        default: B = 17'($urandom);
      endcase
      @(posedge clk); #1;
    end
    flush = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
